// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences the external multiplier and owns the architectural HI/LO registers.
module hilo_ctrl #(
   parameter int LATENCY = 36
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mult_req,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        rd_hi,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   output logic        start,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rdata
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;
   state_t state, state_nxt;
   logic [5:0] cnt;
   logic accept;
   assign accept = (state == S_IDLE) && mult_req;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= S_IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    state_nxt = mult_req ? S_ISSUE : S_IDLE;
         S_ISSUE:   state_nxt = S_WAIT;
         S_WAIT:    state_nxt = (cnt == 6'd1) ? S_CAPTURE : S_WAIT;
         S_CAPTURE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end
   always_comb stall = (state != S_IDLE);
   // The counter only runs in WAIT, so loading LATENCY-1 puts capture at E0+LATENCY.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         mult_a <= '0;
         mult_b <= '0;
         start  <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         start <= accept;
         done  <= (state == S_CAPTURE);
         if (accept) begin
            mult_a <= op_a;
            mult_b <= op_b;
            cnt    <= 6'(LATENCY - 1);
         end
         if (state == S_WAIT) cnt <= cnt - 6'd1;
         if (state == S_CAPTURE) begin
            hi <= mult_hi;
            lo <= mult_lo;
         end else if (state == S_IDLE) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
         end
      end
   assign rdata = rd_hi ? hi : lo;
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed checks of hilo_ctrl driven by a behavioural 35-cycle multiplier.
module tb_hilo_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        mult_req, mthi, mtlo, rd_hi;
   logic [31:0] op_a, op_b, wdata, mult_hi, mult_lo;
   logic [31:0] mult_a, mult_b, hi, lo, rdata;
   logic        start, stall, done;
   int          checks = 0;
   int          errors = 0;

   hilo_ctrl dut (
      .clk(clk), .reset(reset), .mult_req(mult_req), .op_a(op_a), .op_b(op_b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_hi(rd_hi),
      .mult_hi(mult_hi), .mult_lo(mult_lo), .mult_a(mult_a), .mult_b(mult_b),
      .start(start), .stall(stall), .done(done), .hi(hi), .lo(lo), .rdata(rdata)
   );

   always #5 clk = ~clk;

   // Multiplier model: samples start at E0, shows the product from E0+35, junk before that.
   logic [31:0] ma, mb;
   logic [5:0]  mcnt;
   logic [63:0] prod;
   assign prod = {{32{ma[31]}}, ma} * {{32{mb[31]}}, mb};
   always @(posedge clk or posedge reset)
      if (reset) begin
         mcnt <= '0; ma <= '0; mb <= '0; mult_hi <= '0; mult_lo <= '0;
      end else if (start) begin
         mcnt <= 6'd35; ma <= mult_a; mb <= mult_b;
         mult_hi <= 32'hBAD0BAD0; mult_lo <= 32'hBAD0BAD0;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 6'd1;
         if (mcnt == 6'd1) begin
            mult_hi <= prod[63:32];
            mult_lo <= prod[31:0];
         end
      end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues a request from IDLE and returns in the cycle where done is high.
   task automatic run(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el, input bit disturb);
      int n_stall = 0, n_start = 0, i = 0;
      logic [31:0] hi0;
      hi0 = hi;
      op_a = a; op_b = b; mult_req = 1'b1;
      tick();
      mult_req = 1'b0;
      check("start_c0", start, 1);
      while (!done && i < 100) begin
         n_stall += int'(stall);
         n_start += int'(start);
         if (disturb && i == 5) begin
            op_a = 32'h0000FFFF; op_b = 32'h1; mthi = 1'b1; mult_req = 1'b1; wdata = 32'h55555555;
         end
         if (disturb && i == 6) begin
            mthi = 1'b0; mult_req = 1'b0;
         end
         if (disturb && i == 7) begin
            check("hold_a", mult_a, a);
            check("hold_b", mult_b, b);
            check("hold_hi", hi, hi0);
         end
         tick();
         i++;
      end
      check("done_seen", done, 1);
      check("stall_cycles", n_stall, 37);
      check("start_cycles", n_start, 1);
      check("stall_done", stall, 0);
      check("hi", hi, eh);
      check("lo", lo, el);
   endtask

   initial begin
      int n_done;
      reset = 1'b1; mult_req = 1'b0; mthi = 1'b0; mtlo = 1'b0; rd_hi = 1'b0;
      op_a = '0; op_b = '0; wdata = '0;
      repeat (2) tick();
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_ma", mult_a, 0);
      check("rst_mb", mult_b, 0);
      check("rst_start", start, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall, 0);
      reset = 1'b0;
      tick();
      mthi = 1'b1; wdata = 32'h12345678;
      tick();
      mthi = 1'b0; rd_hi = 1'b1;
      #1 check("rd_hi_data", rdata, 32'h12345678);
      mtlo = 1'b1; wdata = 32'hCAFEBABE;
      tick();
      mtlo = 1'b0; rd_hi = 1'b0;
      #1 check("rd_lo_data", rdata, 32'hCAFEBABE);
      check("hi_kept", hi, 32'h12345678);
      #3 reset = 1'b1;
      #1 check("async_hi", hi, 0);
      check("async_lo", lo, 0);
      check("async_stall", stall, 0);
      check("async_rdata", rdata, 0);
      tick();
      reset = 1'b0;
      tick();
      run(32'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
      tick();
      check("done_once", done, 0);
      run(32'd7, 32'd6, 32'd0, 32'd42, 1'b1);
      run(32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
      tick();
      check("b2b_done_once", done, 0);
      op_a = 32'd9; op_b = 32'd9; mult_req = 1'b1;
      tick();
      mult_req = 1'b0;
      repeat (20) tick();
      reset = 1'b1;
      #1 check("mid_rst_stall", stall, 0);
      check("mid_rst_hi", hi, 0);
      check("mid_rst_lo", lo, 0);
      tick();
      reset = 1'b0;
      n_done = 0;
      repeat (50) begin
         n_done += int'(done);
         tick();
      end
      check("mid_rst_no_done", n_done, 0);
      check("mid_rst_hi_after", hi, 0);
      check("mid_rst_lo_after", lo, 0);
      run(32'd5, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0);
      tick();
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
      tick();
      mthi = 1'b0; mtlo = 1'b0;
      check("both_hi", hi, 32'hA5A5A5A5);
      check("both_lo", lo, 32'hA5A5A5A5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencing and architectural-state block that sits directly downstream of the sequential `mult` unit and between it and the CPU datapath. It latches the operands, issues a single-cycle `start` pulse, and counts the multiplier's fixed latency while stalling the pipeline. It then captures the 64-bit product into the architectural HI/LO registers. It also services `mthi`/`mtlo` writes and `mfhi`/`mflo` reads.

## Interface
- `LATENCY`, default 36: number of cycles from the `start` cycle to the capture cycle; the capture edge is the first edge at which `mult` HI/LO hold the new product.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mult_req`  in  1  request a signed multiply of `op_a` × `op_b`.
- `op_a`  in  32  multiplier operand A, sampled on the edge where `mult_req` is accepted.
- `op_b`  in  32  multiplier operand B, sampled with `op_a`.
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  32  data for `mthi`/`mtlo`.
- `rd_hi`  in  1  read select: 1 = HI, 0 = LO.
- `mult_hi`  in  32  HI output of `mult`.
- `mult_lo`  in  32  LO output of `mult`.
- `mult_a`  out  32  registered operand A to `mult`.
- `mult_b`  out  32  registered operand B to `mult`.
- `start`  out  1  registered start pulse to `mult`.
- `stall`  out  1  pipeline hold; high while a multiply is in flight.
- `done`  out  1  one-cycle pulse in the cycle after capture.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.
- `rdata`  out  32  combinational read data: `rd_hi ? hi : lo`.

## Operation
- **States.** IDLE, ISSUE, WAIT, CAPTURE. The state register is 2 bits and the latency counter is 6 bits.
- **IDLE.**
  - If `mult_req` is high: latch `op_a`/`op_b` into `mult_a`/`mult_b`, load the counter with `LATENCY-1`, and go to ISSUE.
  - `mthi`/`mtlo` write HI/LO from `wdata` on the edge.
  - If both `mthi` and `mtlo` are high, both registers get `wdata`.
- **ISSUE.** `start`=1 for exactly this cycle. Next state is WAIT.
- **WAIT.** The counter decrements each edge. When the counter reaches 1, go to CAPTURE.
- **CAPTURE.** On the edge that ends this cycle: `hi`←`mult_hi`, `lo`←`mult_lo`, `done`←1, state←IDLE.
- **Stall.** `stall` = (state ≠ IDLE). `mult_a`/`mult_b` stay constant from ISSUE through CAPTURE.
- **Writes while busy.** `mthi`/`mtlo` outside IDLE are ignored; the pipeline is stalled, so they indicate a protocol error. `mult_req` outside IDLE is also ignored.
- **Simultaneous request and write in IDLE.** `mult_req` with `mthi`/`mtlo` in IDLE: the write takes effect now, and the multiply result overwrites it at capture.
- **Signedness.** The product is signed, as computed by `mult`; this block does no arithmetic.

## Timing
- **Reset values.** All zero: `hi`, `lo`, `mult_a`, `mult_b`, `start`, `done`, and the counter. State goes to IDLE, so `stall`=0.
- **Reset mid-operation.** Returns to IDLE immediately. No capture occurs and `hi`/`lo` are cleared. `mult` shares `reset`, so both restart clean.
- **Request timeline.** Request accepted at edge E: ISSUE is cycle C0 (after E), `start` is sampled by `mult` at edge E0 (end of C0), and `mult` loads the operands in the following cycle.
- **Capture point.** `mult` updates HI/LO at E0+35. This block captures at E0+`LATENCY` = E0+36.
- **Stall window.** `stall` is high for `LATENCY`+1 cycles (C0 through C0+`LATENCY`). `done` and the new `hi`/`lo` are visible in cycle C0+`LATENCY`+1.
- **Back-to-back requests.** A new `mult_req` may be accepted in the same cycle `done` is high. Minimum request spacing is `LATENCY`+2 cycles.
- **`rdata`.** Purely combinational. It reflects writes in the cycle after the write edge.

## Test plan
- **Reset.** Assert `reset` asynchronously between edges → all outputs 0 immediately, `stall`=0.
- **Signed multiply.** `mult_req` with `op_a`=3, `op_b`=32'hFFFFFFFE (−2), driven by a real `mult` → `start` high exactly 1 cycle; `stall` high 37 cycles; then `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFFA, and `done` pulses once.
- **Move and read.** In IDLE, `mthi` with `wdata`=32'h12345678, then `rd_hi`=1 → `rdata`=32'h12345678. Then `mtlo` 32'hCAFEBABE with `rd_hi`=0 → `rdata`=32'hCAFEBABE; `hi` unchanged.
- **Operand hold and ignored inputs.** During WAIT, toggle `op_a`/`op_b` and pulse `mthi`/`mult_req` → `mult_a`/`mult_b` and `hi` unchanged, no second `start`. Result for operands 7 × 6 is `lo`=42, `hi`=0.
- **Reset mid-operation.** Issue a multiply and assert `reset` at C0+20 → `hi`/`lo` stay 0, no `done`. A new request after release gives the correct product.
- **Back-to-back requests.** `mult_req` in the `done` cycle with 32'h80000000 × 32'h80000000 → second `start` exactly 1 cycle after return to IDLE; `hi`=32'h40000000, `lo`=0.
